// File: rtl/camera_state_pkg.sv
// Shared types for the camera pose path: command mode encodings (also used by
// user_control), FSM states, direction bit positions and default widths.
package camera_state_pkg;

  localparam int POS_BITS_DEF = 16;
  localparam int ANG_BITS_DEF = 8;

  // Bit positions inside cmd_dir = {left, right, up, down}
  localparam int DIR_LEFT  = 3;
  localparam int DIR_RIGHT = 2;
  localparam int DIR_UP    = 1;
  localparam int DIR_DOWN  = 0;

  typedef enum logic [1:0] {
    MODE_XY  = 2'd0,
    MODE_XZ  = 2'd1,
    MODE_ROT = 2'd2,
    MODE_NOP = 2'd3
  } cmd_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } cam_state_e;

  // Pose at the default widths: Q8.8 position, unsigned yaw, signed pitch
  typedef struct packed {
    logic signed [POS_BITS_DEF-1:0] x;
    logic signed [POS_BITS_DEF-1:0] y;
    logic signed [POS_BITS_DEF-1:0] z;
    logic        [ANG_BITS_DEF-1:0] yaw;
    logic signed [ANG_BITS_DEF-1:0] pitch;
  } pose_t;

endpackage

// File: rtl/camera_state_pose_step.sv
// Combinational next-shadow-pose calculation for one command: saturating
// position moves, wrapping yaw, pitch clamped to +/-90 degrees.
module camera_state_pose_step
  import camera_state_pkg::*;
#(
  parameter int                  POS_BITS = POS_BITS_DEF,
  parameter logic [POS_BITS-1:0] STEP     = 16'h0040,
  parameter int                  ANG_BITS = ANG_BITS_DEF,
  parameter logic [ANG_BITS-1:0] ANG_STEP = 8'd4
) (
  input  logic signed [POS_BITS-1:0] x_i,
  input  logic signed [POS_BITS-1:0] y_i,
  input  logic signed [POS_BITS-1:0] z_i,
  input  logic        [ANG_BITS-1:0] yaw_i,
  input  logic signed [ANG_BITS-1:0] pitch_i,
  input  cmd_mode_e                  mode_i,
  input  logic        [3:0]          dir_i,
  output logic signed [POS_BITS-1:0] x_o,
  output logic signed [POS_BITS-1:0] y_o,
  output logic signed [POS_BITS-1:0] z_o,
  output logic        [ANG_BITS-1:0] yaw_o,
  output logic signed [ANG_BITS-1:0] pitch_o,
  output logic                       changed_o
);

  localparam logic signed [ANG_BITS:0] PITCH_MAX = (ANG_BITS+1)'(2 ** (ANG_BITS-2));
  localparam logic signed [ANG_BITS:0] PITCH_MIN = -PITCH_MAX;

  // One extra bit holds any single-step overflow; fold it back to the rails
  function automatic logic signed [POS_BITS-1:0] sat_pos(input logic signed [POS_BITS:0] v);
    if (v[POS_BITS] != v[POS_BITS-1])
      sat_pos = v[POS_BITS] ? {1'b1, {(POS_BITS-1){1'b0}}} : {1'b0, {(POS_BITS-1){1'b1}}};
    else
      sat_pos = v[POS_BITS-1:0];
  endfunction

  // Opposing directions cancel to zero
  function automatic logic signed [POS_BITS:0] pos_delta(input logic pos, input logic neg);
    logic signed [POS_BITS:0] s;
    s = $signed({1'b0, STEP});
    case ({pos, neg})
      2'b10:   pos_delta = s;
      2'b01:   pos_delta = -s;
      default: pos_delta = '0;
    endcase
  endfunction

  function automatic logic signed [ANG_BITS-1:0] clamp_pitch(input logic signed [ANG_BITS:0] v);
    if (v > PITCH_MAX)
      clamp_pitch = PITCH_MAX[ANG_BITS-1:0];
    else if (v < PITCH_MIN)
      clamp_pitch = PITCH_MIN[ANG_BITS-1:0];
    else
      clamp_pitch = v[ANG_BITS-1:0];
  endfunction

  logic signed [POS_BITS:0] x_ext, y_ext, z_ext;
  logic signed [ANG_BITS:0] pitch_ext, pitch_delta;
  logic left, right, up, down;

  // Apply one command to the shadow pose
  always_comb begin
    left        = dir_i[DIR_LEFT];
    right       = dir_i[DIR_RIGHT];
    up          = dir_i[DIR_UP];
    down        = dir_i[DIR_DOWN];
    x_ext       = {x_i[POS_BITS-1], x_i};
    y_ext       = {y_i[POS_BITS-1], y_i};
    z_ext       = {z_i[POS_BITS-1], z_i};
    pitch_ext   = {pitch_i[ANG_BITS-1], pitch_i};
    pitch_delta = '0;
    x_o         = x_i;
    y_o         = y_i;
    z_o         = z_i;
    yaw_o       = yaw_i;
    pitch_o     = pitch_i;
    case (mode_i)
      MODE_XY: begin
        x_o = sat_pos(x_ext + pos_delta(right, left));
        y_o = sat_pos(y_ext + pos_delta(up, down));
      end
      MODE_XZ: begin
        x_o = sat_pos(x_ext + pos_delta(right, left));
        z_o = sat_pos(z_ext + pos_delta(up, down));
      end
      MODE_ROT: begin
        case ({right, left})
          2'b10:   yaw_o = yaw_i + ANG_STEP;
          2'b01:   yaw_o = yaw_i - ANG_STEP;
          default: yaw_o = yaw_i;
        endcase
        case ({up, down})
          2'b10:   pitch_delta = $signed({1'b0, ANG_STEP});
          2'b01:   pitch_delta = -$signed({1'b0, ANG_STEP});
          default: pitch_delta = '0;
        endcase
        pitch_o = clamp_pitch(pitch_ext + pitch_delta);
      end
      default: ;
    endcase
    changed_o = (x_o != x_i) || (y_o != y_i) || (z_o != z_i) ||
                (yaw_o != yaw_i) || (pitch_o != pitch_i);
  end

endmodule

// File: rtl/camera_state.sv
// Camera pose holder: commands edit a shadow pose; the live (output) pose and
// fractal selection change only on frame_done so a frame never sees a mix.
module camera_state
  import camera_state_pkg::*;
#(
  parameter int                  POS_BITS = POS_BITS_DEF,
  parameter logic [POS_BITS-1:0] STEP     = 16'h0040,
  parameter int                  ANG_BITS = ANG_BITS_DEF,
  parameter logic [ANG_BITS-1:0] ANG_STEP = 8'd4,
  parameter logic [POS_BITS-1:0] CAM_Z0   = 16'hFC00
) (
  input  logic                       clk_in,
  input  logic                       rst_in_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_mode,
  input  logic [3:0]                 cmd_dir,
  input  logic [2:0]                 fractal_sel_in,
  input  logic                       frame_done,
  output logic signed [POS_BITS-1:0] cam_x,
  output logic signed [POS_BITS-1:0] cam_y,
  output logic signed [POS_BITS-1:0] cam_z,
  output logic        [ANG_BITS-1:0] cam_yaw,
  output logic signed [ANG_BITS-1:0] cam_pitch,
  output logic [2:0]                 fractal_sel,
  output logic                       pose_valid
);

  cam_state_e state_q, state_d;
  logic signed [POS_BITS-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_z_q, sh_z_d;
  logic        [ANG_BITS-1:0] sh_yaw_q, sh_yaw_d;
  logic signed [ANG_BITS-1:0] sh_pitch_q, sh_pitch_d;
  logic signed [POS_BITS-1:0] lv_x_q, lv_x_d, lv_y_q, lv_y_d, lv_z_q, lv_z_d;
  logic        [ANG_BITS-1:0] lv_yaw_q, lv_yaw_d;
  logic signed [ANG_BITS-1:0] lv_pitch_q, lv_pitch_d;
  logic [2:0] fsel_q, fsel_d;
  logic       dirty_q, dirty_d;
  logic       pose_valid_q, pose_valid_d;
  logic       cmd_ready_q, cmd_ready_d;

  logic signed [POS_BITS-1:0] nx_x, nx_y, nx_z;
  logic        [ANG_BITS-1:0] nx_yaw;
  logic signed [ANG_BITS-1:0] nx_pitch;
  logic                       step_changed;
  logic                       accept, shadow_chg;

  camera_state_pose_step #(
    .POS_BITS (POS_BITS),
    .STEP     (STEP),
    .ANG_BITS (ANG_BITS),
    .ANG_STEP (ANG_STEP)
  ) u_pose_step (
    .x_i       (sh_x_q),
    .y_i       (sh_y_q),
    .z_i       (sh_z_q),
    .yaw_i     (sh_yaw_q),
    .pitch_i   (sh_pitch_q),
    .mode_i    (cmd_mode_e'(cmd_mode)),
    .dir_i     (cmd_dir),
    .x_o       (nx_x),
    .y_o       (nx_y),
    .z_o       (nx_z),
    .yaw_o     (nx_yaw),
    .pitch_o   (nx_pitch),
    .changed_o (step_changed)
  );

  assign accept     = cmd_valid && cmd_ready_q;
  assign shadow_chg = accept && step_changed;

  // Next-state, shadow update and commit decisions
  always_comb begin
    state_d    = state_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_z_d     = sh_z_q;
    sh_yaw_d   = sh_yaw_q;
    sh_pitch_d = sh_pitch_q;
    lv_x_d     = lv_x_q;
    lv_y_d     = lv_y_q;
    lv_z_d     = lv_z_q;
    lv_yaw_d   = lv_yaw_q;
    lv_pitch_d = lv_pitch_q;
    fsel_d     = fsel_q;
    dirty_d    = dirty_q;
    if (accept) begin
      sh_x_d     = nx_x;
      sh_y_d     = nx_y;
      sh_z_d     = nx_z;
      sh_yaw_d   = nx_yaw;
      sh_pitch_d = nx_pitch;
    end
    case (state_q)
      ST_IDLE: begin
        if (frame_done) begin
          fsel_d = fractal_sel_in;
          if (fractal_sel_in != fsel_q) begin
            // Shadow equals live here, so only the fractal actually changes
            state_d = ST_COMMIT;
            dirty_d = shadow_chg;
          end else if (shadow_chg) begin
            state_d = ST_PENDING;
          end
        end else if (shadow_chg) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_done) begin
          // Live takes the pre-command shadow; a same-cycle command waits a frame
          lv_x_d     = sh_x_q;
          lv_y_d     = sh_y_q;
          lv_z_d     = sh_z_q;
          lv_yaw_d   = sh_yaw_q;
          lv_pitch_d = sh_pitch_q;
          fsel_d     = fractal_sel_in;
          state_d    = ST_COMMIT;
          dirty_d    = shadow_chg;
        end
      end
      ST_COMMIT: begin
        state_d = dirty_q ? ST_PENDING : ST_IDLE;
        dirty_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    pose_valid_d = (state_d == ST_COMMIT);
    cmd_ready_d  = (state_d != ST_COMMIT);
  end

  // State, pose and registered outputs; reset discards uncommitted commands
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q      <= ST_IDLE;
      sh_x_q       <= '0;
      sh_y_q       <= '0;
      sh_z_q       <= CAM_Z0;
      sh_yaw_q     <= '0;
      sh_pitch_q   <= '0;
      lv_x_q       <= '0;
      lv_y_q       <= '0;
      lv_z_q       <= CAM_Z0;
      lv_yaw_q     <= '0;
      lv_pitch_q   <= '0;
      fsel_q       <= '0;
      dirty_q      <= 1'b0;
      pose_valid_q <= 1'b0;
      cmd_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_x_q       <= sh_x_d;
      sh_y_q       <= sh_y_d;
      sh_z_q       <= sh_z_d;
      sh_yaw_q     <= sh_yaw_d;
      sh_pitch_q   <= sh_pitch_d;
      lv_x_q       <= lv_x_d;
      lv_y_q       <= lv_y_d;
      lv_z_q       <= lv_z_d;
      lv_yaw_q     <= lv_yaw_d;
      lv_pitch_q   <= lv_pitch_d;
      fsel_q       <= fsel_d;
      dirty_q      <= dirty_d;
      pose_valid_q <= pose_valid_d;
      cmd_ready_q  <= cmd_ready_d;
    end
  end

  assign cam_x       = lv_x_q;
  assign cam_y       = lv_y_q;
  assign cam_z       = lv_z_q;
  assign cam_yaw     = lv_yaw_q;
  assign cam_pitch   = lv_pitch_q;
  assign fractal_sel = fsel_q;
  assign pose_valid  = pose_valid_q;
  assign cmd_ready   = cmd_ready_q;

endmodule

// File: doc/camera_state.md
CAMERA_STATE -- requirements
Module: camera_state

Interface
REQ-001 Parameter POS_BITS, default 16, signed Q8.8 width of each camera coordinate.
REQ-002 Parameter STEP, default 16'h0040 (0.25), translation increment per accepted command.
REQ-003 Parameter ANG_BITS, default 8, angle width; 2^ANG_BITS steps per full turn.
REQ-004 Parameter ANG_STEP, default 4, yaw/pitch increment per accepted command.
REQ-005 Parameter CAM_Z0, default 16'hFC00 (-4.0), reset value of cam_z.
REQ-006 clk_in  input  1  system clock; the only clock.
REQ-007 rst_in_n  input  1  reset, asynchronous assert, active-low.
REQ-008 cmd_valid  input  1  command present.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-010 cmd_mode  input  2  0 translate XY, 1 translate XZ, 2 rotate, 3 no-op.
REQ-011 cmd_dir  input  4  {left, right, up, down}; any combination legal.
REQ-012 fractal_sel_in  input  3  requested fractal.
REQ-013 frame_done  input  1  one-cycle pulse from the renderer at the end of a frame.
REQ-014 cam_x, cam_y, cam_z  output  POS_BITS each  committed position, signed.
REQ-015 cam_yaw, cam_pitch  output  ANG_BITS each  committed angles; yaw unsigned, pitch signed.
REQ-016 fractal_sel  output  3  committed fractal.
REQ-017 pose_valid  output  1  one-cycle pulse when committed outputs change.

Function
REQ-018 Block holds a shadow pose (x, y, z, yaw, pitch) updated by commands and a live pose (outputs) updated only at frame boundaries, so a frame never renders with a mixed pose.
REQ-019 FSM states: IDLE (shadow == live), PENDING (shadow differs), COMMIT (one-cycle copy).
REQ-020 cmd_ready is 1 in IDLE and PENDING, 0 in COMMIT.
REQ-021 An accepted command updates the shadow at the same edge, moving IDLE -> PENDING; mode 3 or cmd_dir == 0 is accepted with no change and no state transition.
REQ-022 Mode 0: x += STEP*(right - left); y += STEP*(up - down). Mode 1: x as mode 0; z += STEP*(up - down). Opposing directions cancel.
REQ-023 Mode 2: yaw += ANG_STEP*(right - left), modulo 2^ANG_BITS; pitch += ANG_STEP*(up - down), clamped to [-2^(ANG_BITS-2), +2^(ANG_BITS-2)] (±90°).
REQ-024 Position arithmetic computed at POS_BITS+1 bits and saturated to [-2^(POS_BITS-1), 2^(POS_BITS-1)-1]; no wrap.
REQ-025 frame_done in PENDING: next edge copies shadow to live, samples fractal_sel_in into fractal_sel, and enters COMMIT; pose_valid = 1 throughout COMMIT.
REQ-026 frame_done in IDLE: fractal_sel is sampled; if it changes, the block enters COMMIT and pulses pose_valid, otherwise it stays IDLE with no pulse.
REQ-027 A command accepted in the same cycle as frame_done updates the shadow, but live receives the pre-command shadow; this command lands in the next frame.
REQ-028 COMMIT -> PENDING if a command changed the shadow in the frame_done cycle, else COMMIT -> IDLE.
REQ-029 frame_done asserted during COMMIT is ignored.
REQ-030 Latency: command to shadow is 1 edge; frame_done to outputs and pose_valid is 1 edge.

Reset
REQ-031 While rst_in_n = 0: state IDLE; shadow and live x = y = 0, z = CAM_Z0, yaw = pitch = 0; fractal_sel = 0; pose_valid = 0; cmd_ready = 0.
REQ-032 Reset mid-PENDING or mid-COMMIT discards all uncommitted commands; the first cycle after release has cmd_ready = 1.

Structure
REQ-033 Shared package (types.sv) holds the cmd_mode encodings (shared with user_control), the pose struct typedef, and the default POS_BITS/ANG_BITS values.
REQ-034 Sub-module pose_step (combinational: shadow pose, mode, dir -> next shadow with saturation, wrap and clamp) is instantiated once.

Verification
REQ-035 Reset then mode 0, dir right, then frame_done -> cam_x = 16'h0040, cam_z = 16'hFC00, pose_valid high for 1 cycle.
REQ-036 Mode 0 right 3 times with no frame_done -> cam_x stays 0; after frame_done -> cam_x = 16'h00C0.
REQ-037 Command and frame_done in the same cycle from PENDING with shadow x = 0x40, command right -> live x = 0x40, state PENDING; next frame_done -> x = 0x80.
REQ-038 Preload x = 16'h7FF0, command right, frame_done -> cam_x = 16'h7FFF. Mode 2 left from yaw 0 -> yaw = 8'hFC. Seventeen ups -> pitch = 8'h40.
REQ-039 Mode 2, dir {left, right} -> yaw unchanged, state IDLE, no pose_valid on the following frame_done.
REQ-040 Assert rst_in_n = 0 during COMMIT -> outputs return to reset values; pose_valid is 0 the cycle after release.
